// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg: shared types, CSR addresses and bit positions for the machine-mode trap controller.
package trap_ctrl_pkg;
    typedef enum logic [30:0] {
        EXC_INSTR_MISALIGNED = 31'd0,
        EXC_INSTR_FAULT      = 31'd1,
        EXC_ILLEGAL_INSTR    = 31'd2,
        EXC_BREAKPOINT       = 31'd3,
        EXC_LOAD_MISALIGNED  = 31'd4,
        EXC_LOAD_FAULT       = 31'd5,
        EXC_STORE_MISALIGNED = 31'd6,
        EXC_STORE_FAULT      = 31'd7,
        EXC_ECALL_M          = 31'd11
    } exception_code_e;

    typedef enum logic [30:0] {
        IRQ_CODE_M_SOFT  = 31'd3,
        IRQ_CODE_M_TIMER = 31'd7,
        IRQ_CODE_M_EXT   = 31'd11
    } interrupt_code_e;

    typedef enum logic [11:0] {
        CSR_MSTATUS  = 12'h300,
        CSR_MIE      = 12'h304,
        CSR_MTVEC    = 12'h305,
        CSR_MSCRATCH = 12'h340,
        CSR_MEPC     = 12'h341,
        CSR_MCAUSE   = 12'h342,
        CSR_MTVAL    = 12'h343,
        CSR_MIP      = 12'h344
    } csr_addr_e;

    typedef enum logic {MTVEC_DIRECT = 1'b0, MTVEC_VECTORED = 1'b1} csr_mtvec_mode_e;

    typedef enum logic {TRAP_STATE_RUN, TRAP_STATE_SLEEP} trap_state_e;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;
    localparam int IRQ_MSI        = 3;
    localparam int IRQ_MTI        = 7;
    localparam int IRQ_MEI        = 11;
    localparam int MCAUSE_IRQ_BIT = 31;
    localparam logic [31:0] IRQ_MASK = 32'h0000_0888;
endpackage

// File: rtl/trap_ctrl_irq_sel.sv
// trap_irq_sel: fixed-priority pick of the pending interrupt (EXT > SW > TIMER).
module trap_irq_sel
    import trap_ctrl_pkg::*;
(
    input  logic [31:0] pend_i,
    output logic        valid_o,
    output logic [30:0] code_o
);
    // pend only ever carries the three mip bits, so any set bit is a real request
    assign valid_o = |pend_i;
    assign code_o  = pend_i[IRQ_MEI] ? IRQ_CODE_M_EXT :
                     pend_i[IRQ_MSI] ? IRQ_CODE_M_SOFT : IRQ_CODE_M_TIMER;
endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap CSRs plus exception/interrupt entry, MRET and WFI sleep sequencing.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter int          XLEN        = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            exc_valid_i,
    input  logic [30:0]     exc_code_i,
    input  logic [XLEN-1:0] exc_pc_i,
    input  logic [XLEN-1:0] exc_tval_i,
    input  logic            mret_i,
    input  logic            wfi_i,
    input  logic            boundary_valid_i,
    input  logic [XLEN-1:0] boundary_pc_i,
    input  logic            irq_sw_i,
    input  logic            irq_timer_i,
    input  logic            irq_ext_i,
    input  logic            csr_we_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    output logic [XLEN-1:0] csr_rdata_o,
    output logic            csr_hit_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            stall_o,
    output logic            irq_taken_o
);
    trap_state_e     state_q;
    logic            mstatus_mie_q, mstatus_mpie_q;
    logic [XLEN-1:0] mip_d, mip_q, mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
    logic [XLEN-1:0] pend, mstatus_rd, trap_base, trap_pc_d, trap_epc_d;
    logic            redirect_valid_q, irq_taken_q;
    logic [XLEN-1:0] redirect_pc_q;
    logic            irq_valid, run, take_exc, take_mret, take_irq, go_sleep, csr_wr;
    logic [30:0]     irq_code;

    trap_irq_sel u_irq_sel (.pend_i(pend), .valid_o(irq_valid), .code_o(irq_code));

    assign pend      = mip_q & mie_q;
    assign run       = state_q == TRAP_STATE_RUN;
    // a frozen pipeline cannot raise exceptions, retire MRET or write CSRs
    assign take_exc  = run && exc_valid_i;
    assign take_mret = run && !exc_valid_i && mret_i;
    assign take_irq  = !take_exc && !take_mret && mstatus_mie_q && irq_valid && boundary_valid_i;
    assign go_sleep  = run && wfi_i && !exc_valid_i && !mret_i && !take_irq;
    assign csr_wr    = run && csr_we_i && !exc_valid_i && !mret_i && !take_irq && !wfi_i;

    assign trap_base  = {mtvec_q[XLEN-1:2], 2'b00};
    assign trap_pc_d  = (mtvec_q[0] == MTVEC_VECTORED && !take_exc) ?
                        trap_base + ({1'b0, irq_code} << 2) : trap_base;
    assign trap_epc_d = take_exc ? exc_pc_i : boundary_pc_i;

    assign stall_o          = !run && !(|pend);
    assign redirect_valid_o = redirect_valid_q;
    assign redirect_pc_o    = redirect_pc_q;
    assign irq_taken_o      = irq_taken_q;

    always_comb begin
        mip_d = '0;
        mip_d[IRQ_MEI] = irq_ext_i;
        mip_d[IRQ_MTI] = irq_timer_i;
        mip_d[IRQ_MSI] = irq_sw_i;
        mstatus_rd = '0;
        mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        mstatus_rd[MSTATUS_MIE]  = mstatus_mie_q;
        mstatus_rd[MSTATUS_MPIE] = mstatus_mpie_q;
    end

    always_comb begin
        csr_hit_o   = 1'b1;
        csr_rdata_o = '0;
        case (csr_addr_i)
            CSR_MSTATUS:  csr_rdata_o = mstatus_rd;
            CSR_MIE:      csr_rdata_o = mie_q;
            CSR_MTVEC:    csr_rdata_o = mtvec_q;
            CSR_MSCRATCH: csr_rdata_o = mscratch_q;
            CSR_MEPC:     csr_rdata_o = mepc_q;
            CSR_MCAUSE:   csr_rdata_o = mcause_q;
            CSR_MTVAL:    csr_rdata_o = mtval_q;
            CSR_MIP:      csr_rdata_o = mip_q;
            default:      csr_hit_o   = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= TRAP_STATE_RUN;
            mstatus_mie_q    <= 1'b0;
            mstatus_mpie_q   <= 1'b0;
            mip_q            <= '0;
            mie_q            <= '0;
            mtvec_q          <= MTVEC_RESET & ~32'h2;
            mscratch_q       <= '0;
            mepc_q           <= '0;
            mcause_q         <= '0;
            mtval_q          <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            irq_taken_q      <= 1'b0;
        end else begin
            mip_q            <= mip_d;
            redirect_valid_q <= take_exc || take_mret || take_irq;
            redirect_pc_q    <= take_mret ? mepc_q : (take_exc || take_irq) ? trap_pc_d : '0;
            irq_taken_q      <= take_irq;
            state_q          <= go_sleep ? TRAP_STATE_SLEEP : (|pend || take_irq) ? TRAP_STATE_RUN : state_q;
            if (take_exc || take_irq) begin
                mepc_q         <= {trap_epc_d[XLEN-1:2], 2'b00};
                mcause_q       <= take_exc ? {1'b0, exc_code_i} : {1'b1, irq_code};
                mtval_q        <= take_exc ? exc_tval_i : '0;
                mstatus_mpie_q <= mstatus_mie_q;
                mstatus_mie_q  <= 1'b0;
            end else if (take_mret) begin
                mstatus_mie_q  <= mstatus_mpie_q;
                mstatus_mpie_q <= 1'b1;
            end else if (csr_wr) begin
                case (csr_addr_i)
                    CSR_MSTATUS: begin
                        mstatus_mie_q  <= csr_wdata_i[MSTATUS_MIE];
                        mstatus_mpie_q <= csr_wdata_i[MSTATUS_MPIE];
                    end
                    CSR_MIE:      mie_q      <= csr_wdata_i & IRQ_MASK;
                    CSR_MTVEC:    mtvec_q    <= csr_wdata_i & ~32'h2;
                    CSR_MSCRATCH: mscratch_q <= csr_wdata_i;
                    CSR_MEPC:     mepc_q     <= {csr_wdata_i[XLEN-1:2], 2'b00};
                    CSR_MCAUSE:   mcause_q   <= csr_wdata_i;
                    CSR_MTVAL:    mtval_q    <= csr_wdata_i;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed scenarios with a redirect scoreboard checked after every clock edge.
module tb_trap_ctrl;
    localparam logic [31:0] RST_VEC = 32'h0000_0101;

    typedef struct {
        logic [31:0] pc;
        logic        irq;
    } redir_t;

    logic        clk = 1'b0;
    logic        rst, exc_valid_i, mret_i, wfi_i, boundary_valid_i;
    logic [30:0] exc_code_i;
    logic [31:0] exc_pc_i, exc_tval_i, boundary_pc_i, csr_wdata_i;
    logic        irq_sw_i, irq_timer_i, irq_ext_i, csr_we_i;
    logic [11:0] csr_addr_i;
    logic [31:0] csr_rdata_o, redirect_pc_o;
    logic        csr_hit_o, redirect_valid_o, stall_o, irq_taken_o;

    redir_t exp_q[$];
    int     pass_n = 0;
    int     total_n = 0;

    trap_ctrl #(.MTVEC_RESET(RST_VEC), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .exc_valid_i(exc_valid_i), .exc_code_i(exc_code_i), .exc_pc_i(exc_pc_i), .exc_tval_i(exc_tval_i),
        .mret_i(mret_i), .wfi_i(wfi_i),
        .boundary_valid_i(boundary_valid_i), .boundary_pc_i(boundary_pc_i),
        .irq_sw_i(irq_sw_i), .irq_timer_i(irq_timer_i), .irq_ext_i(irq_ext_i),
        .csr_we_i(csr_we_i), .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i),
        .csr_rdata_o(csr_rdata_o), .csr_hit_o(csr_hit_o),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
        .stall_o(stall_o), .irq_taken_o(irq_taken_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_n++;
        assert (obs === exp) pass_n++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        redir_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("redirect_valid", {31'b0, redirect_valid_o}, 32'd1);
            chk("redirect_pc", redirect_pc_o, e.pc);
            chk("irq_taken", {31'b0, irq_taken_o}, {31'b0, e.irq});
        end else begin
            chk("no_redirect", {31'b0, redirect_valid_o}, 32'd0);
            chk("no_irq_taken", {31'b0, irq_taken_o}, 32'd0);
        end
    endtask

    task automatic clr();
        exc_valid_i = 0; exc_code_i = '0; exc_pc_i = '0; exc_tval_i = '0;
        mret_i = 0; wfi_i = 0; boundary_valid_i = 0; boundary_pc_i = '0;
        csr_we_i = 0; csr_wdata_i = '0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csr_we_i = 1; csr_addr_i = a; csr_wdata_i = d;
        tick();
        csr_we_i = 0;
    endtask

    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        csr_addr_i = a;
        #1;
        chk(tag, csr_rdata_o, exp);
    endtask

    task automatic chk_stall(input string tag, input logic exp);
        chk(tag, {31'b0, stall_o}, {31'b0, exp});
    endtask

    initial begin
        clr();
        irq_sw_i = 0; irq_timer_i = 0; irq_ext_i = 0; csr_addr_i = 12'h300;
        rst = 1;
        tick(); tick();
        rst = 0;
        chk_stall("reset_stall", 1'b0);
        rd("reset_mtvec", 12'h305, RST_VEC);
        rd("reset_mstatus", 12'h300, 32'h0000_1800);
        rd("reset_mepc", 12'h341, 32'h0);
        rd("reset_mcause", 12'h342, 32'h0);

        // illegal instruction to direct base
        wr(12'h305, 32'h200);
        wr(12'h300, 32'h8);
        rd("mstatus_mie_set", 12'h300, 32'h0000_1808);
        exc_valid_i = 1; exc_code_i = 31'd2; exc_pc_i = 32'h100; exc_tval_i = 32'h0;
        exp_q.push_back('{32'h200, 1'b0});
        tick(); clr();
        rd("illegal_mepc", 12'h341, 32'h100);
        rd("illegal_mcause", 12'h342, 32'h2);
        rd("illegal_mtval", 12'h343, 32'h0);
        rd("illegal_mstatus", 12'h300, 32'h0000_1880);

        // vectored timer interrupt; first boundary is too early for the synchronised line
        wr(12'h305, 32'h401);
        wr(12'h304, 32'h80);
        wr(12'h300, 32'h8);
        irq_timer_i = 1; boundary_valid_i = 1; boundary_pc_i = 32'h344;
        tick();
        exp_q.push_back('{32'h41C, 1'b1});
        tick(); clr(); irq_timer_i = 0;
        rd("timer_mcause", 12'h342, 32'h8000_0007);
        rd("timer_mepc", 12'h341, 32'h344);
        rd("timer_mtval", 12'h343, 32'h0);
        rd("timer_mstatus", 12'h300, 32'h0000_1880);

        // exception beats simultaneous interrupts, then EXT beats SW
        wr(12'h305, 32'h400);
        wr(12'h304, 32'h888);
        wr(12'h300, 32'h8);
        irq_ext_i = 1; irq_sw_i = 1;
        tick();
        boundary_valid_i = 1; boundary_pc_i = 32'h500;
        exc_valid_i = 1; exc_code_i = 31'd5; exc_pc_i = 32'h600; exc_tval_i = 32'h1234_5678;
        exp_q.push_back('{32'h400, 1'b0});
        tick(); clr();
        rd("prio_exc_mcause", 12'h342, 32'h5);
        rd("prio_exc_mepc", 12'h341, 32'h600);
        rd("prio_exc_mtval", 12'h343, 32'h1234_5678);
        wr(12'h300, 32'h8);
        boundary_valid_i = 1; boundary_pc_i = 32'h504;
        exp_q.push_back('{32'h400, 1'b1});
        tick(); clr(); irq_ext_i = 0; irq_sw_i = 0;
        rd("prio_irq_mcause", 12'h342, 32'h8000_000B);
        rd("prio_irq_mepc", 12'h341, 32'h504);
        tick();

        // MRET
        wr(12'h341, 32'h1234);
        wr(12'h300, 32'h80);
        mret_i = 1;
        exp_q.push_back('{32'h1234, 1'b0});
        tick(); clr();
        rd("mret_mstatus", 12'h300, 32'h0000_1888);

        // WFI with MIE=0: wake without redirect
        wr(12'h300, 32'h0);
        wr(12'h304, 32'h8);
        wfi_i = 1;
        tick(); clr();
        chk_stall("wfi0_stall_rise", 1'b1);
        tick();
        chk_stall("wfi0_stall_hold", 1'b1);
        irq_sw_i = 1;
        #1;
        chk_stall("wfi0_stall_unsynced", 1'b1);
        tick();
        chk_stall("wfi0_stall_drop", 1'b0);
        tick();
        chk_stall("wfi0_run", 1'b0);
        irq_sw_i = 0;
        tick(); tick();

        // WFI with MIE=1: wake and take the interrupt at the next boundary
        wr(12'h305, 32'h200);
        wr(12'h300, 32'h8);
        wfi_i = 1;
        tick(); clr();
        chk_stall("wfi1_stall_rise", 1'b1);
        irq_sw_i = 1;
        tick();
        chk_stall("wfi1_stall_drop", 1'b0);
        boundary_valid_i = 1; boundary_pc_i = 32'h704;
        exp_q.push_back('{32'h200, 1'b1});
        tick(); clr(); irq_sw_i = 0;
        rd("wfi1_mepc", 12'h341, 32'h704);
        rd("wfi1_mcause", 12'h342, 32'h8000_0003);
        tick();

        // CSR masking, read-only mip and non-owned address
        wr(12'h304, 32'hFFFF_FFFF);
        wr(12'h305, 32'hFFFF_FFFF);
        wr(12'h341, 32'hFFFF_FFFF);
        rd("mask_mie", 12'h304, 32'h888);
        rd("mask_mtvec", 12'h305, 32'hFFFF_FFFD);
        rd("mask_mepc", 12'h341, 32'hFFFF_FFFC);
        wr(12'h300, 32'hFFFF_FFFF);
        rd("mask_mstatus", 12'h300, 32'h0000_1888);
        wr(12'h340, 32'hA5A5_5A5A);
        rd("mscratch_rw", 12'h340, 32'hA5A5_5A5A);
        chk("mscratch_hit", {31'b0, csr_hit_o}, 32'd1);
        wr(12'h7C0, 32'hFFFF_FFFF);
        rd("unowned_rdata", 12'h7C0, 32'h0);
        chk("unowned_hit", {31'b0, csr_hit_o}, 32'd0);
        irq_timer_i = 1;
        tick();
        rd("mip_timer", 12'h344, 32'h80);
        wr(12'h344, 32'h0);
        rd("mip_readonly", 12'h344, 32'h80);
        irq_timer_i = 0;
        tick();
        wr(12'h300, 32'h0);

        // SLEEP ignores CSR writes and exceptions; reset wakes and cancels redirects
        wfi_i = 1;
        tick(); clr();
        chk_stall("sleep_stall", 1'b1);
        wr(12'h340, 32'h1);
        rd("sleep_csr_ignored", 12'h340, 32'hA5A5_5A5A);
        exc_valid_i = 1; exc_code_i = 31'd2; exc_pc_i = 32'h900;
        tick();
        rst = 1;
        tick(); clr();
        rst = 0;
        chk_stall("rst_stall", 1'b0);
        rd("rst_mtvec", 12'h305, RST_VEC);
        rd("rst_mscratch", 12'h340, 32'h0);
        tick();

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Machine-mode trap controller for the RV32I core. It owns the trap CSRs: mstatus (MIE/MPIE), mie, mip, mtvec, mscratch, mepc, mcause and mtval. It sequences exception entry, interrupt entry, MRET and WFI sleep. It issues a one-cycle PC redirect to fetch and a stall to the pipeline. It sits beside the execute/writeback stage and serves all CSR instructions.

Parameters:
MTVEC_RESET, 32'h0000_0000, reset value of mtvec (base and mode)
XLEN, 32, data width; only 32 supported

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
exc_valid_i  in  1  exception raised by the instruction in writeback
exc_code_i  in  31  exception_code_e of that exception
exc_pc_i  in  32  PC of the faulting instruction
exc_tval_i  in  32  trap value (bad address or instruction bits)
mret_i  in  1  MRET retiring
wfi_i  in  1  WFI retiring
boundary_valid_i  in  1  an instruction boundary is available for interrupt entry
boundary_pc_i  in  32  PC of the next unexecuted instruction at that boundary
irq_sw_i / irq_timer_i / irq_ext_i  in  1 each  level interrupt lines (MSIP/MTIP/MEIP)
csr_we_i  in  1  CSR write strobe; already resolved RW/RS/RC value
csr_addr_i  in  12  CSR address (csr_addr_e)
csr_wdata_i  in  32  final write value
csr_rdata_o  out  32  combinational read data for csr_addr_i
csr_hit_o  out  1  csr_addr_i is one of the eight CSRs owned here
redirect_valid_o  out  1  one-cycle pulse: fetch from redirect_pc_o
redirect_pc_o  out  32  target PC
stall_o  out  1  high while in SLEEP; freezes fetch/issue
irq_taken_o  out  1  one-cycle pulse with redirect when the cause is an interrupt

Behaviour:
- Reset: all CSRs 0 except mtvec=MTVEC_RESET. State RUN. redirect_valid_o=0, redirect_pc_o=0, stall_o=0, irq_taken_o=0.
- mip is read-only: {MEIP[11], MTIP[7], MSIP[3]} are the input lines registered once (1-cycle sync). mie writable bits are 11, 7 and 3 only. mstatus writable bits are MIE[3] and MPIE[7]; MPP reads 2'b11.
- mtvec[1] reads 0; mtvec[0] is the mode (csr_mtvec_mode_e). mepc[1:0] reads 0.
- Event priority within one cycle: exc_valid_i > mret_i > interrupt > wfi_i > csr_we_i. A lower-priority event in the same cycle is dropped; the pipeline flushes it.
- Pending interrupt: pend = mip & mie. Take it when mstatus.MIE && |pend && boundary_valid_i. Selection order: EXT(11) > SW(3) > TIMER(7).
- Trap entry (exception or interrupt), applied at the clock edge:
  - mepc <= exc_pc_i or boundary_pc_i.
  - mcause <= {is_irq, code}.
  - mtval <= exc_tval_i for exceptions, 0 for interrupts.
  - MPIE <= MIE; MIE <= 0.
- Trap target: {mtvec[31:2],2'b00}. In VECTORED mode with an interrupt, add 4*code. Exceptions always go to the base.
- MRET: MIE <= MPIE; MPIE <= 1; target = mepc.
- Redirect latency: registered. redirect_valid_o and redirect_pc_o appear exactly 1 cycle after the triggering input and last 1 cycle. irq_taken_o pulses alongside for interrupts.
- An exception while MIE=0 (nested in a handler) is still taken normally; no double-trap handling.
- FSM states: RUN and SLEEP.
  - RUN -> SLEEP on wfi_i with no higher-priority event that cycle. stall_o rises the next cycle.
  - SLEEP -> RUN when |pend, independent of mstatus.MIE. stall_o drops the same cycle pend is seen.
  - On wake with MIE=1, the interrupt is taken at the next boundary_valid_i (mepc = PC after WFI). With MIE=0, execution resumes with no redirect.
  - In SLEEP, csr_we_i and exc_valid_i are ignored (pipeline frozen).
- Reset mid-operation: rst has priority over all events. It returns the FSM to RUN and cancels any pending redirect pulse.
- CSR write on a non-owned address: no effect; csr_hit_o=0 and csr_rdata_o=0.

Decomposition:
- Add to RiscvPkg:
  - trap_state_e {TRAP_STATE_RUN, TRAP_STATE_SLEEP}
  - bit-index constants for mstatus MIE=3, MPIE=7, MPP=12:11
  - interrupt bit positions MSI=3, MTI=7, MEI=11
  - MCAUSE_IRQ_BIT=31
- Existing exception_code_e, interrupt_code_e, csr_addr_e and csr_mtvec_mode_e are used as-is.
- One natural sub-module: trap_irq_sel. It is combinational: takes pend and outputs a valid flag plus the interrupt_code_e by fixed priority.

Test Plan:
- Illegal instruction: exc_valid_i=1, code=2, pc=0x100, tval=0x0000_0000, mtvec=0x200 -> next cycle redirect 0x200; mepc=0x100, mcause=0x2, MIE 1->0 with MPIE=1.
- Vectored timer interrupt: mtvec=0x401, mie=0x80, MIE=1, irq_timer_i=1, boundary_pc=0x344 -> redirect 0x41C; mcause=0x8000_0007, mepc=0x344, irq_taken_o pulse.
- Priority: irq_ext_i and irq_sw_i asserted together, all enabled -> mcause=0x8000_000B. Same cycle exc_valid_i=1 -> exception cause, no irq_taken_o.
- MRET: mepc=0x1234, MPIE=1 -> redirect 0x1234; MIE=1, MPIE=1.
- WFI with MIE=0, mie=0x8: stall_o held; raise irq_sw_i -> stall_o drops, no redirect. Repeat with MIE=1 -> trap taken, mepc = WFI pc+4.
- CSR masking and reset: write 0xFFFF_FFFF to mie/mtvec/mepc -> read 0x888/0xFFFF_FFFD/0xFFFF_FFFC. Assert rst during SLEEP -> stall_o=0, mtvec=MTVEC_RESET next cycle.
